alu32: RTL and testbench
========================

ALU32 -- requirements
Module: alu32

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  32  operand A (two's complement for signed ops).
REQ-005 B  input  32  operand B.
REQ-006 C_in  input  1  carry-in, used by ADD and the sum flags only.
REQ-007 S2, S1, S0  input  1 each  opcode bits; S2 is MSB.
REQ-008 R  output  32  registered result.
REQ-009 C_out_sum  output  1  registered carry-out of A+B+C_in.
REQ-010 C_out_sub  output  1  registered carry-out of A+~B+1 (1 = no borrow).
REQ-011 Zero_bit  output  1  registered, 1 when the registered R equals zero.
REQ-012 V_sum  output  1  registered signed overflow of A+B+C_in.
REQ-013 V_sub  output  1  registered signed overflow of A-B.

Function
REQ-014 Opcode {S2,S1,S0}: 000 ADD R=A+B+C_in; 001 SUB R=A-B; 010 AND; 011 OR; 100 SLT R={31'b0, signed(A)<signed(B)}; 101 NOR; 110 XOR; 111 SLL R=A<<B[4:0].
REQ-015 Inputs are sampled on each rising clk edge; all outputs update on that edge, 1-cycle latency, no handshake, new operation accepted every cycle.
REQ-016 Sum flags (C_out_sum, V_sum) are computed from A+B+C_in every cycle, regardless of opcode.
REQ-017 Sub flags (C_out_sub, V_sub) are computed from A+~B+1 every cycle, regardless of opcode; C_in is ignored by subtraction.
REQ-018 V_sum = (A[31]==B[31]) && (sum[31]!=A[31]); V_sub = (A[31]!=B[31]) && (diff[31]!=A[31]).
REQ-019 Arithmetic wraps modulo 2^32; carries and overflows appear only in the flags.
REQ-020 SLT uses the exact signed comparison and is unaffected by subtraction overflow.
REQ-021 Zero_bit is derived from the same result value loaded into R in that cycle, for every opcode.
REQ-022 SLL with B[4:0]=0 passes A unchanged; B[31:5] is ignored.

Reset
REQ-023 When rst=1 at a rising edge, R, C_out_sum, C_out_sub, Zero_bit, V_sum and V_sub are all 0 after that edge, regardless of other inputs.
REQ-024 rst has priority over any operation in the same cycle; the first valid result appears one edge after rst deasserts.

Structure
REQ-025 Shared package alu32_pkg holds the 3-bit opcode type and named constants for the eight opcodes.
REQ-026 One sub-module, adder32 (32-bit adder with carry-in, carry-out and overflow), is instantiated twice: once for the sum and once for the subtraction, with ~B and carry-in 1.
REQ-027 The result mux and flags are combinational, feeding one output register stage; no other state exists.

Verification
REQ-028 SLT: A=3, B=3, op 100, C_in=0 -> R=0, Zero_bit=1, C_out_sub=1, V_sub=0, C_out_sum=0, V_sum=0.
REQ-029 ADD: A=32'hFFFFFFFF, B=1, C_in=0, op 000 -> R=0, Zero_bit=1, C_out_sum=1, V_sum=0.
REQ-030 Overflow: A=32'h7FFFFFFF, B=1, op 000 -> R=32'h80000000, V_sum=1; A=32'h80000000, B=1, op 001 -> R=32'h7FFFFFFF, V_sub=1.
REQ-031 SLT signed: A=32'hFFFFFFFF (-1), B=1, op 100 -> R=1, Zero_bit=0; swapped operands -> R=0, Zero_bit=1.
REQ-032 Logic/shift: A=32'hF0F0F0F0, B=32'h0FF00FF0 -> AND 32'h00F000F0, OR 32'hFFF0FFF0, XOR 32'hFF00FF00, NOR 32'h000F000F; SLL with A=1, B=31 -> 32'h80000000.
REQ-033 Reset: drive ADD producing nonzero flags, assert rst for one edge -> all outputs 0; deassert -> correct result one edge later.

Source files
------------

// File: rtl/alu32_pkg.sv
// -----------------------------------------------------------------------------
// alu32_pkg
// Shared definitions for the 32-bit ALU: datapath width and the 3-bit opcode
// encoding {S2,S1,S0} with a named constant for each of the eight operations.
// -----------------------------------------------------------------------------
package alu32_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b100,
    OP_NOR = 3'b101,
    OP_XOR = 3'b110,
    OP_SLL = 3'b111
  } alu_op_e;

endpackage : alu32_pkg

// File: rtl/alu32_adder32.sv
// -----------------------------------------------------------------------------
// adder32
// Purely combinational 32-bit adder with carry-in, carry-out and two's
// complement overflow. Used twice by alu32: once for A+B+C_in and once for
// A+~B+1 (subtraction).
// Ports:
//   a_i, b_i  : 32-bit addends
//   c_i       : carry-in
//   s_o       : 32-bit sum (wraps modulo 2^32)
//   c_o       : carry-out of bit 31
//   v_o       : signed overflow (operands agree in sign, sum does not)
// -----------------------------------------------------------------------------
module adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] s_o,
  output logic        c_o,
  output logic        v_o
);

  logic [32:0] full_s;

  // 33-bit sum so the carry-out falls out of the top bit.
  assign full_s = {1'b0, a_i} + {1'b0, b_i} + {32'b0, c_i};
  assign s_o    = full_s[31:0];
  assign c_o    = full_s[32];
  assign v_o    = (a_i[31] == b_i[31]) && (full_s[31] != a_i[31]);

endmodule : adder32

// File: rtl/alu32.sv
// -----------------------------------------------------------------------------
// alu32
// 32-bit ALU with a single output register stage (1-cycle latency, one new
// operation per cycle). Sum and subtraction flags are produced every cycle
// regardless of the selected opcode.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset, clears every output
//   A, B       : 32-bit operands (two's complement for signed ops)
//   C_in       : carry-in, used only by ADD and the sum flags
//   S2,S1,S0   : opcode {S2,S1,S0}, see alu32_pkg::alu_op_e
//   R          : registered result
//   C_out_sum  : registered carry-out of A+B+C_in
//   C_out_sub  : registered carry-out of A+~B+1 (1 = no borrow)
//   Zero_bit   : registered, set when the registered R is zero
//   V_sum      : registered signed overflow of A+B+C_in
//   V_sub      : registered signed overflow of A-B
// -----------------------------------------------------------------------------
module alu32
  import alu32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        C_in,
  input  logic        S2,
  input  logic        S1,
  input  logic        S0,
  output logic [31:0] R,
  output logic        C_out_sum,
  output logic        C_out_sub,
  output logic        Zero_bit,
  output logic        V_sum,
  output logic        V_sub
);

  alu_op_e     op_s;
  logic [31:0] sum_s;
  logic        c_sum_s;
  logic        v_sum_s;
  logic [31:0] diff_s;
  logic        c_sub_s;
  logic        v_sub_s;
  logic        slt_s;

  logic [31:0] r_d,     r_q;
  logic        zero_d,  zero_q;
  logic        c_sum_q, c_sub_q;
  logic        v_sum_q, v_sub_q;

  assign op_s = alu_op_e'({S2, S1, S0});

  adder32 u_add_sum (
    .a_i (A),
    .b_i (B),
    .c_i (C_in),
    .s_o (sum_s),
    .c_o (c_sum_s),
    .v_o (v_sum_s)
  );

  // Subtraction as A + ~B + 1; C_in deliberately not involved.
  adder32 u_add_sub (
    .a_i (A),
    .b_i (~B),
    .c_i (1'b1),
    .s_o (diff_s),
    .c_o (c_sub_s),
    .v_o (v_sub_s)
  );

  // Exact signed compare, so SLT is not fooled by subtraction overflow.
  assign slt_s = ($signed(A) < $signed(B));

  // Result mux selected by opcode; zero flag taken from the same value.
  always_comb begin
    r_d = 32'h0000_0000;
    unique case (op_s)
      OP_ADD:  r_d = sum_s;
      OP_SUB:  r_d = diff_s;
      OP_AND:  r_d = A & B;
      OP_OR:   r_d = A | B;
      OP_SLT:  r_d = {31'b0, slt_s};
      OP_NOR:  r_d = ~(A | B);
      OP_XOR:  r_d = A ^ B;
      OP_SLL:  r_d = A << B[4:0];
      default: r_d = 32'h0000_0000;
    endcase
    zero_d = (r_d == 32'h0000_0000);
  end

  // Single output register stage; reset wins over any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= 32'h0000_0000;
      zero_q  <= 1'b0;
      c_sum_q <= 1'b0;
      c_sub_q <= 1'b0;
      v_sum_q <= 1'b0;
      v_sub_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      zero_q  <= zero_d;
      c_sum_q <= c_sum_s;
      c_sub_q <= c_sub_s;
      v_sum_q <= v_sum_s;
      v_sub_q <= v_sub_s;
    end
  end

  assign R         = r_q;
  assign Zero_bit  = zero_q;
  assign C_out_sum = c_sum_q;
  assign C_out_sub = c_sub_q;
  assign V_sum     = v_sum_q;
  assign V_sub     = v_sub_q;

endmodule : alu32

// File: tb/tb_alu32.sv
// -----------------------------------------------------------------------------
// tb_alu32
// Self-checking bench for alu32: a behavioural model evaluated on each rising
// edge from the sampled inputs, a compare process on each falling edge, a set
// of hand-computed literal vectors, and a randomized phase.
// -----------------------------------------------------------------------------
module tb_alu32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic        C_in;
  logic        S2, S1, S0;
  logic [31:0] R;
  logic        C_out_sum, C_out_sub, Zero_bit, V_sum, V_sub;

  int n_checks = 0;
  int n_fail   = 0;

  // Model expectations for the outputs after the most recent rising edge.
  logic [31:0] e_r;
  logic        e_z, e_cs, e_cb, e_vs, e_vb;
  logic        e_valid = 1'b0;

  alu32 dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .C_in      (C_in),
    .S2        (S2),
    .S1        (S1),
    .S0        (S0),
    .R         (R),
    .C_out_sum (C_out_sum),
    .C_out_sub (C_out_sub),
    .Zero_bit  (Zero_bit),
    .V_sum     (V_sum),
    .V_sub     (V_sub)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer arithmetic on the sampled inputs.
  longint          m_sa, m_sb, m_ssum, m_sdiff;
  longint unsigned m_usum;
  logic [2:0]      m_op;
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      e_r = 32'h0; e_z = 1'b0; e_cs = 1'b0; e_cb = 1'b0; e_vs = 1'b0; e_vb = 1'b0;
    end else begin
      m_sa    = $signed(A);
      m_sb    = $signed(B);
      m_ssum  = m_sa + m_sb + longint'(C_in);
      m_sdiff = m_sa - m_sb;
      m_usum  = longint'(A) + longint'(B) + longint'(C_in);
      e_cs    = (m_usum >= 64'h1_0000_0000);
      e_cb    = (A >= B);
      e_vs    = (m_ssum > 64'sd2147483647) || (m_ssum < -64'sd2147483648);
      e_vb    = (m_sdiff > 64'sd2147483647) || (m_sdiff < -64'sd2147483648);
      m_op    = {S2, S1, S0};
      case (m_op)
        3'd0: e_r = m_usum[31:0];
        3'd1: e_r = A - B;
        3'd2: e_r = A & B;
        3'd3: e_r = A | B;
        3'd4: e_r = (m_sa < m_sb) ? 32'd1 : 32'd0;
        3'd5: e_r = ~(A | B);
        3'd6: e_r = A ^ B;
        default: e_r = A << B[4:0];
      endcase
      e_z = (e_r == 32'h0);
    end
    e_valid = 1'b1;
  end

  // Compare process: every falling edge once the model has an expectation.
  always @(negedge clk) begin
    if (e_valid) begin
      check("model R",         R,         e_r);
      check("model Zero_bit",  {31'b0, Zero_bit},  {31'b0, e_z});
      check("model C_out_sum", {31'b0, C_out_sum}, {31'b0, e_cs});
      check("model C_out_sub", {31'b0, C_out_sub}, {31'b0, e_cb});
      check("model V_sum",     {31'b0, V_sum},     {31'b0, e_vs});
      check("model V_sub",     {31'b0, V_sub},     {31'b0, e_vb});
    end
  end

  // Drive one vector just after a falling edge.
  task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [2:0] op);
    @(negedge clk);
    rst = r; A = a; B = b; C_in = cin; {S2, S1, S0} = op;
  endtask

  // Wait until the applied vector has been registered, then sample.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; A = 32'h1234_5678; B = 32'h0000_0001; C_in = 1'b1; {S2, S1, S0} = 3'b000;
    settle();
    check("reset R",         R, 32'h0);
    check("reset flags",     {27'b0, Zero_bit, C_out_sum, C_out_sub, V_sum, V_sub}, 32'h0);

    // SLT equal operands
    apply(1'b0, 32'd3, 32'd3, 1'b0, 3'b100); settle();
    check("slt eq R", R, 32'h0);
    check("slt eq flags Z/Cs/Cb/Vs/Vb",
          {27'b0, Zero_bit, C_out_sum, C_out_sub, V_sum, V_sub}, {27'b0, 5'b10100});

    // ADD wrap to zero
    apply(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b000); settle();
    check("add wrap R", R, 32'h0);
    check("add wrap Z/Cs/Vs", {29'b0, Zero_bit, C_out_sum, V_sum}, {29'b0, 3'b110});

    // Signed overflow on sum and on difference
    apply(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 3'b000); settle();
    check("add ovf R", R, 32'h8000_0000);
    check("add ovf V_sum", {31'b0, V_sum}, 32'd1);
    apply(1'b0, 32'h8000_0000, 32'd1, 1'b0, 3'b001); settle();
    check("sub ovf R", R, 32'h7FFF_FFFF);
    check("sub ovf V_sub", {31'b0, V_sub}, 32'd1);

    // Signed SLT both ways
    apply(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b100); settle();
    check("slt neg R/Z", {R[30:0], Zero_bit}, {31'd1, 1'b0});
    apply(1'b0, 32'd1, 32'hFFFF_FFFF, 1'b0, 3'b100); settle();
    check("slt swap R/Z", {R[30:0], Zero_bit}, {31'd0, 1'b1});

    // Logic and shift
    apply(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'b010); settle();
    check("and R", R, 32'h00F0_00F0);
    apply(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'b011); settle();
    check("or R", R, 32'hFFF0_FFF0);
    apply(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'b110); settle();
    check("xor R", R, 32'hFF00_FF00);
    apply(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'b101); settle();
    check("nor R", R, 32'h000F_000F);
    apply(1'b0, 32'd1, 32'd31, 1'b0, 3'b111); settle();
    check("sll 31 R", R, 32'h8000_0000);
    apply(1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 1'b0, 3'b111); settle();
    check("sll 0 ignores B[31:5]", R, 32'hDEAD_BEEF);

    // ADD with carry-in
    apply(1'b0, 32'd10, 32'd20, 1'b1, 3'b000); settle();
    check("add cin R", R, 32'd31);

    // Reset mid-stream: flags set, then cleared, then recovered
    apply(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'b000); settle();
    check("pre-rst R", R, 32'hFFFF_FFFF);
    check("pre-rst C_out_sum", {31'b0, C_out_sum}, 32'd1);
    apply(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'b000); settle();
    check("rst R", R, 32'h0);
    check("rst flags", {27'b0, Zero_bit, C_out_sum, C_out_sub, V_sum, V_sub}, 32'h0);
    apply(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'b000); settle();
    check("post-rst R", R, 32'hFFFF_FFFF);
    check("post-rst C_out_sum", {31'b0, C_out_sum}, 32'd1);

    // Randomized phase, one vector per cycle, occasional reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 49) == 0);
      A    = pick_operand();
      B    = pick_operand();
      C_in = 1'($urandom_range(0, 1));
      {S2, S1, S0} = 3'($urandom_range(0, 7));
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu32
